// File: rtl/seq_alu_if.sv
// Handshake bundle for seq_alu: an issue-side request channel and a writeback-side response channel.
// The master drives the operation and the out_ready back-pressure. The slave (the ALU) drives the results.
`timescale 1ns/1ps
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_zero;
    logic             flag_neg;
    logic             flag_carry;
    logic             flag_ovf;
    logic             div_by_zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi,
        input  flag_zero, flag_neg, flag_carry, flag_ovf, div_by_zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi,
        output flag_zero, flag_neg, flag_carry, flag_ovf, div_by_zero
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift ops, plus an iterative shift-add multiply
// and a restoring divide. Both run for WIDTH cycles and share one pair of work registers.
`timescale 1ns/1ps
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus,
    output logic [1:0] dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready depends only on state. Once out_valid is raised, the outputs are held until out_ready.
    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_LSR = 4'h8;
    localparam logic [3:0] OP_LSL = 4'h9;
    localparam logic [3:0] OP_ASR = 4'hA;
    localparam logic [3:0] OP_ROR = 4'hB;
    localparam logic [3:0] OP_ROL = 4'hC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] hi_q;
    logic             zero_q;
    logic             neg_q;
    logic             carry_q;
    logic             ovf_q;
    logic             dbz_q;

    logic accept;
    logic last_iter;
    assign accept    = bus.in_valid && (state == IDLE);
    assign last_iter = (state == BUSY) && (cnt == LAST_CNT);

    // One iteration of each long op. MUL keeps {hi,lo} as the partial product.
    // DIV keeps the remainder in hi and shifts the quotient bits into lo.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {work_hi, work_lo[MSB]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = (div_shift >= {1'b0, b_q});
        if (op_q == OP_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo[MSB:1]};
        end else begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {work_lo[MSB-1:0], div_ge};
        end
    end

    // Results for everything that completes straight from IDLE. These are computed from the live inputs.
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] s_res;
    logic [WIDTH-1:0] s_hi;
    logic             s_carry;
    logic             s_ovf;
    logic             s_dbz;
    logic             s_multi;

    always_comb begin
        add_sum = {1'b0, bus.a} + {1'b0, bus.b};
        sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
        s_res   = '0;
        s_hi    = '0;
        s_carry = 1'b0;
        s_ovf   = 1'b0;
        s_dbz   = 1'b0;
        s_multi = 1'b0;
        case (bus.op)
            OP_ADD: begin
                s_res   = add_sum[WIDTH-1:0];
                s_carry = add_sum[WIDTH];
                s_ovf   = (bus.a[MSB] == bus.b[MSB]) && (add_sum[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                s_res   = sub_sum[WIDTH-1:0];
                s_carry = sub_sum[WIDTH];
                s_ovf   = (bus.a[MSB] != bus.b[MSB]) && (sub_sum[MSB] != bus.a[MSB]);
            end
            OP_MUL: s_multi = 1'b1;
            OP_DIV: begin
                if (bus.b == '0) begin
                    s_res = '1;
                    s_hi  = bus.a;
                    s_dbz = 1'b1;
                end else begin
                    s_multi = 1'b1;
                end
            end
            OP_AND: s_res = bus.a & bus.b;
            OP_OR:  s_res = bus.a | bus.b;
            OP_NOT: s_res = ~bus.a;
            OP_XOR: s_res = bus.a ^ bus.b;
            OP_LSR: begin
                s_res   = {1'b0, bus.a[MSB:1]};
                s_carry = bus.a[0];
            end
            OP_LSL: begin
                s_res   = {bus.a[MSB-1:0], 1'b0};
                s_carry = bus.a[MSB];
            end
            OP_ASR: begin
                s_res   = {bus.a[MSB], bus.a[MSB:1]};
                s_carry = bus.a[0];
            end
            OP_ROR: begin
                s_res   = {bus.a[0], bus.a[MSB:1]};
                s_carry = bus.a[0];
            end
            OP_ROL: begin
                s_res   = {bus.a[MSB-1:0], bus.a[MSB]};
                s_carry = bus.a[MSB];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = s_multi ? BUSY : DONE;
            BUSY: if (last_iter) state_n = DONE;
            DONE: if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            b_q     <= '0;
            work_hi <= '0;
            work_lo <= '0;
            cnt     <= '0;
        end else if (accept) begin
            op_q    <= bus.op;
            b_q     <= bus.b;
            work_hi <= '0;
            work_lo <= bus.a;
            cnt     <= '0;
        end else if (state == BUSY) begin
            work_hi <= step_hi;
            work_lo <= step_lo;
            cnt     <= cnt + CNT_W'(1);
        end
    end

    // The output registers load only on the transition into DONE.
    // This keeps the outputs stable while they are held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else if (accept && !s_multi) begin
            res_q   <= s_res;
            hi_q    <= s_hi;
            zero_q  <= (s_res == '0);
            neg_q   <= s_res[MSB];
            carry_q <= s_carry;
            ovf_q   <= s_ovf;
            dbz_q   <= s_dbz;
        end else if (last_iter) begin
            res_q   <= step_lo;
            hi_q    <= step_hi;
            zero_q  <= (step_lo == '0);
            neg_q   <= step_lo[MSB];
            carry_q <= (op_q == OP_MUL) && (step_hi != '0);
            ovf_q   <= (op_q == OP_MUL) && (step_hi != '0);
            dbz_q   <= 1'b0;
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.result      = res_q;
    assign bus.result_hi   = hi_q;
    assign bus.flag_zero   = zero_q;
    assign bus.flag_neg    = neg_q;
    assign bus.flag_carry  = carry_q;
    assign bus.flag_ovf    = ovf_q;
    assign bus.div_by_zero = dbz_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=8: directed corner vectors, random ops against an arithmetic model,
// back-pressure, back-to-back issue, and reset during a multiply.
`timescale 1ns/1ps
module tb_seq_alu;
  localparam int W = 8;
  localparam int MAX_WAIT = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  seq_alu_if #(.WIDTH(W)) bus();

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  logic [20:0] exp_q[$];
  int          lat_q[$];

  // Packed layout: {result, result_hi, zero, neg, carry, ovf, div_by_zero}
  function automatic logic [20:0] model(input int op, input int a, input int b, output int lat);
    int r, hi, c, v, d, sa, sb, t;
    r = 0; hi = 0; c = 0; v = 0; d = 0; lat = 1;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      0: begin t = a + b; r = t % 256; c = int'(t >= 256); v = int'((sa + sb) > 127 || (sa + sb) < -128); end
      1: begin r = (a - b + 256) % 256; c = int'(a >= b); v = int'((sa - sb) > 127 || (sa - sb) < -128); end
      2: begin r = (a * b) % 256; hi = (a * b) / 256; c = int'(hi != 0); v = c; lat = W + 1; end
      3: begin
        if (b == 0) begin r = 255; hi = a; d = 1; end
        else begin r = a / b; hi = a % b; lat = W + 1; end
      end
      4: r = a & b;
      5: r = a | b;
      6: r = 255 - a;
      7: r = a ^ b;
      8: begin r = a / 2; c = a % 2; end
      9: begin r = (a * 2) % 256; c = a / 128; end
      10: begin r = a / 2 + (a / 128) * 128; c = a % 2; end
      11: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
      12: begin r = (a * 2) % 256 + a / 128; c = a / 128; end
      default: ;
    endcase
    return {r[7:0], hi[7:0], (r == 0), (r >= 128), c[0], v[0], d[0]};
  endfunction

  function automatic logic [20:0] observe();
    return {bus.result, bus.result_hi, bus.flag_zero, bus.flag_neg,
            bus.flag_carry, bus.flag_ovf, bus.div_by_zero};
  endfunction

  // Issues one op, waits for out_valid, then completes the output handshake.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic [20:0] obs, output int lat,
                      output bit ready_while_busy, output bit ready_after);
    int guard;
    guard = 0;
    ready_while_busy = 1'b0;
    @(negedge clk);
    while (!bus.in_ready && guard < MAX_WAIT) begin
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 4'($urandom);
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < MAX_WAIT) begin
      if (bus.in_ready) ready_while_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    obs = observe();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    ready_after = bus.in_ready && !bus.out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL reset_handshake got %b want 01", {bus.out_valid, bus.in_ready});
    else pass_cnt++;
    total++;
    if (observe() !== 21'h0) $display("FAIL reset_outputs got %h want 0", observe());
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0]  ops[9]  = '{4'h0, 4'h0, 4'h1, 4'h1, 4'hC, 4'hA, 4'h2, 4'h3, 4'h3};
    logic [7:0]  as[9]   = '{8'h7F, 8'hFF, 8'h05, 8'h10, 8'h81, 8'h80, 8'hFF, 8'hC8, 8'h5A};
    logic [7:0]  bs[9]   = '{8'h01, 8'h01, 8'h07, 8'h10, 8'h00, 8'h00, 8'hFF, 8'h07, 8'h00};
    logic [20:0] exps[9] = '{{8'h80, 8'h00, 5'b01010}, {8'h00, 8'h00, 5'b10100},
                             {8'hFE, 8'h00, 5'b01000}, {8'h00, 8'h00, 5'b10100},
                             {8'h03, 8'h00, 5'b00100}, {8'hC0, 8'h00, 5'b01000},
                             {8'h01, 8'hFE, 5'b00110}, {8'h1C, 8'h04, 5'b00000},
                             {8'hFF, 8'h5A, 5'b01001}};
    int          lats[9] = '{1, 1, 1, 1, 1, 1, 9, 9, 1};
    logic [20:0] obs;
    int          lat;
    bit          rwb, ra;
    for (int i = 0; i < 9; i++) begin
      send(ops[i], as[i], bs[i], obs, lat, rwb, ra);
      total++;
      if (obs !== exps[i]) $display("FAIL directed_%0d result got %h want %h", i, obs, exps[i]);
      else pass_cnt++;
      total++;
      if (lat !== lats[i]) $display("FAIL directed_%0d latency got %0d want %0d", i, lat, lats[i]);
      else pass_cnt++;
      total++;
      if (rwb !== 1'b0) $display("FAIL directed_%0d in_ready_busy got 1 want 0", i);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [7:0]  a, b;
    logic [20:0] obs, e;
    int          lat, el;
    bit          rwb, ra;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      exp_q.push_back(model(int'(op), int'(a), int'(b), el));
      lat_q.push_back(el);
      send(op, a, b, obs, lat, rwb, ra);
      e = exp_q.pop_front();
      el = lat_q.pop_front();
      total++;
      if (obs !== e) $display("FAIL random_%0d op=%h a=%h b=%h got %h want %h", i, op, a, b, obs, e);
      else pass_cnt++;
      total++;
      if (lat !== el) $display("FAIL random_%0d latency op=%h got %0d want %0d", i, op, lat, el);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [20:0] first;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 4'h0;
    bus.a = 8'h03;
    bus.b = 8'h04;
    @(posedge clk); #1;
    bus.op = 4'h1;
    bus.a = 8'h09;
    bus.b = 8'h01;
    first = observe();
    total++;
    if (!bus.out_valid || first !== {8'h07, 8'h00, 5'b00000}) $display("FAIL bp_first got v=%b %h want v=1 %h", bus.out_valid, first, {8'h07, 8'h00, 5'b00000});
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({bus.out_valid, bus.in_ready, observe()} !== {2'b10, first})
        $display("FAIL bp_hold_%0d got v=%b r=%b %h want v=1 r=0 %h", i, bus.out_valid, bus.in_ready, observe(), first);
      else pass_cnt++;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL bp_release got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready);
    else pass_cnt++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    if (bus.out_valid) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a, b;
    logic [20:0] obs, e;
    int          lat, el;
    bit          rwb, ra;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      e = model((i % 2 == 0) ? 2 : 3, int'(a), int'(b), el);
      send((i % 2 == 0) ? 4'h2 : 4'h3, a, b, obs, lat, rwb, ra);
      total++;
      if (obs !== e || lat !== el) $display("FAIL b2b_%0d got %h lat %0d want %h lat %0d", i, obs, lat, e, el);
      else pass_cnt++;
      total++;
      if (ra !== 1'b1) $display("FAIL b2b_%0d ready_after got 0 want 1", i);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [20:0] obs;
    int          lat;
    bit          rwb, ra;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 4'h2;
    bus.a = 8'hA5;
    bus.b = 8'h3C;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL midrst_handshake got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready);
    else pass_cnt++;
    total++;
    if (observe() !== 21'h0) $display("FAIL midrst_outputs got %h want 0", observe());
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    send(4'h0, 8'h02, 8'h03, obs, lat, rwb, ra);
    total++;
    if (obs !== {8'h05, 8'h00, 5'b00000} || lat !== 1) $display("FAIL midrst_add got %h lat %0d want %h lat 1", obs, lat, {8'h05, 8'h00, 5'b00000});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
